// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO unit: op codes, FSM state and divider result fields.
// Field positions are given for the reference 32-bit width and rebased by users for other widths.
package hilo_pkg;

    localparam int HILO_W = 32;

    localparam logic [1:0] OP_DIV  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_MTHI = 2'd2;
    localparam logic [1:0] OP_MTLO = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } hilo_state_e;

    // Divider output layout: quotient in the upper half, remainder in the lower half.
    localparam int QUO_MSB = 2*HILO_W - 1;
    localparam int QUO_LSB = HILO_W;
    localparam int REM_MSB = HILO_W - 1;
    localparam int REM_LSB = 0;

    function automatic logic is_div_op(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/hilo_unit.sv
// HI/LO register owner and DIV/DIVU sequencer in EX: one start pulse, stall until the divider answers.
// Divide latency = divider latency + 2 cycles; MTHI/MTLO write at the end of their cycle.
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           op_valid,
    input  logic [1:0]     op,
    input  logic [W-1:0]   op_a,
    input  logic [W-1:0]   op_b,
    input  logic           flush,
    output logic           stall,
    output logic           div_start,
    output logic           div_sign,
    output logic [W-1:0]   div_a,
    output logic [W-1:0]   div_b,
    input  logic           div_busy,
    input  logic           div_ok,
    input  logic [2*W-1:0] div_result,
    output logic [W-1:0]   hi,
    output logic [W-1:0]   lo
);

    // Package field positions rebased from the reference width onto W.
    localparam int QUO_HI = QUO_MSB + 2*(W - HILO_W);
    localparam int QUO_LO = QUO_LSB + (W - HILO_W);
    localparam int REM_HI = REM_MSB + (W - HILO_W);
    localparam int REM_LO = REM_LSB;

    hilo_state_e state_q, state_d;

    logic [W-1:0] hi_q, hi_d;
    logic [W-1:0] lo_q, lo_d;
    logic [W-1:0] div_a_q, div_a_d;
    logic [W-1:0] div_b_q, div_b_d;
    logic         div_sign_q, div_sign_d;

    logic div_req;
    logic accept;
    logic mt_wr;
    logic res_wr;

    // A divide by zero is architecturally undefined: it is dropped without touching the divider.
    assign div_req = op_valid && is_div_op(op) && (op_b != '0) && !flush;
    assign accept  = (state_q == ST_IDLE) && div_req;
    // Moves are also served in DRAIN because the pipeline is not held there.
    assign mt_wr   = op_valid && !flush && !is_div_op(op)
                     && ((state_q == ST_IDLE) || (state_q == ST_DRAIN));
    assign res_wr  = (state_q == ST_WAIT) && div_ok && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = flush ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                // A result arriving with a flush is consumed and dropped; nothing is left to drain.
                if (div_ok) begin
                    state_d = ST_IDLE;
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (div_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stall     = 1'b0;
        div_start = 1'b0;
        unique case (state_q)
            ST_IDLE:  stall = accept;
            ST_ISSUE: begin
                stall     = 1'b1;
                div_start = 1'b1;
            end
            ST_WAIT:  stall = 1'b1;
            ST_DRAIN: stall = div_req;
            default:  stall = 1'b0;
        endcase
    end

    always_comb begin
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_a_d    = div_a_q;
        div_b_d    = div_b_q;
        div_sign_d = div_sign_q;

        if (accept) begin
            div_a_d    = op_a;
            div_b_d    = op_b;
            div_sign_d = (op == OP_DIV);
        end

        if (mt_wr) begin
            if (op == OP_MTHI) begin
                hi_d = op_a;
            end else begin
                lo_d = op_a;
            end
        end

        if (res_wr) begin
            lo_d = div_result[QUO_HI:QUO_LO];
            hi_d = div_result[REM_HI:REM_LO];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q       <= '0;
            lo_q       <= '0;
            div_a_q    <= '0;
            div_b_q    <= '0;
            div_sign_q <= 1'b0;
        end else begin
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_a_q    <= div_a_d;
            div_b_q    <= div_b_d;
            div_sign_q <= div_sign_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_a    = div_a_q;
    assign div_b    = div_b_q;
    assign div_sign = div_sign_q;

    // The divider must report work in progress for as long as we are waiting on it.
    a_busy_while_waiting: assert property (
        @(posedge clk) disable iff (rst)
        (((state_q == ST_WAIT) || (state_q == ST_DRAIN)) && !div_ok) |-> div_busy
    );

endmodule

// File: doc/hilo_unit.md
# hilo_unit

- Owns the HI/LO architectural registers.
- Sequences DIV/DIVU through the `div` wrapper in the EX stage.
- Accepts the divide or move-to request from EX, issues one start pulse to the divider and holds the pipeline stalled while the divider works.
- Captures the 64-bit result into HI/LO and serves MTHI/MTLO writes and HI/LO reads for MFHI/MFLO.

## Interface
Parameters:
- `W`, default 32: data width of operands, HI and LO.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `op_valid` in 1: EX presents a HI/LO-affecting instruction this cycle.
- `op` in 2: `OP_DIV`=0, `OP_DIVU`=1, `OP_MTHI`=2, `OP_MTLO`=3.
- `op_a` in W: rs value, the dividend or move data.
- `op_b` in W: rt value, the divisor.
- `flush` in 1: exception/flush; cancels an in-flight divide.
- `stall` out 1: hold IF..EX; combinational.
- `div_start` out 1: one-cycle pulse to the divider's `sourceData`.
- `div_sign` out 1: 1 = signed.
- `div_a` out W: dividend, registered.
- `div_b` out W: divisor, registered.
- `div_busy` in 1: divider `hasData`.
- `div_ok` in 1: divider `dataOK`, a one-cycle pulse.
- `div_result` in 2W: divider output; quotient is [2W-1:W], remainder is [W-1:0].
- `hi` out W: registered.
- `lo` out W: registered.

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN.
- IDLE, `op_valid` with MTHI or MTLO: write `op_a` into HI or LO at the edge. No stall.
- IDLE, `op_valid` with DIV or DIVU and `op_b`≠0:
  - latch `op_a`/`op_b` into `div_a`/`div_b`;
  - latch `div_sign` = (op==DIV);
  - go to ISSUE.
- IDLE, `op_valid` with DIV or DIVU and `op_b`==0:
  - MIPS result is undefined; the divider is not started;
  - HI/LO stay unchanged and there is no stall.
- ISSUE: `div_start`=1 for exactly this cycle, then go to WAIT.
- WAIT, on `div_ok`: LO ← quotient and HI ← remainder, then go to IDLE.
- WAIT, on `flush`: go to DRAIN. The divider cannot be aborted.
- DRAIN, on `div_ok`: discard the result, leave HI/LO untouched, go to IDLE.
- ISSUE, on `flush`: `div_start` is still pulsed, then go to DRAIN.
- `flush` in IDLE with `op_valid`: the op is ignored. No write and no issue.
- `stall` = (IDLE & `op_valid` & op∈{DIV,DIVU} & `op_b`≠0 & !`flush`) | state∈{ISSUE,WAIT}.
  - Stall is not raised in DRAIN; the flushed pipeline refills.
  - A new divide arriving while in DRAIN stalls until IDLE.
- HI/LO reads are the register outputs. No bypass of a same-cycle MTHI/MTLO write.
- `div_busy` is for assertions only: it must be 1 in WAIT/DRAIN before `div_ok`.
- Reset values: state=IDLE, `hi`=`lo`=0, `div_start`=0, `div_sign`=0, `div_a`=`div_b`=0. With state=IDLE and `op_valid`=0, `stall`=0.
- Reset mid-divide: return to IDLE immediately. A later stray `div_ok` in IDLE is ignored and does not write HI/LO.

## Timing
- Cycle 0: divide accepted, `stall`=1.
- Cycle 1: ISSUE, `div_start`=1, operands stable; the divider samples them at the end of cycle 1.
- Cycle k: `div_ok`=1, and HI/LO update at the end of cycle k.
- Cycle k+1: IDLE, `stall`=0, and the new `hi`/`lo` are visible.
- Total stall = divider latency + 2 cycles.
- `div_a`, `div_b` and `div_sign` hold from ISSUE until the next acceptance.
- `div_ok` outside WAIT/DRAIN is ignored.
- MTHI/MTLO take effect at the end of the cycle they are presented in.

## Structure
- The shared package `hilo_pkg` holds:
  - op encodings `OP_DIV`, `OP_DIVU`, `OP_MTHI`, `OP_MTLO`;
  - the state encoding (2 bits);
  - field slices `QUO_MSB`/`QUO_LSB` and `REM_MSB`/`REM_LSB`.
- No sub-module. The FSM and HI/LO registers stay in one file.
- The instantiating EX top connects this block to `div`.

## Test plan
- Reset, then DIVU a=100, b=7, with the divider answering after 20 cycles:
  - one `div_start` pulse, in the cycle after acceptance;
  - `stall` high for 22 cycles;
  - LO=14, HI=2.
- DIV a=−7 (0xFFFFFFF9), b=2:
  - `div_sign`=1;
  - LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MTHI 0xDEADBEEF then MTLO 0x12345678 on back-to-back cycles:
  - no stall;
  - `hi`/`lo` equal those values one cycle after each write.
- DIV with b=0: no `div_start`, `stall` stays 0, HI/LO unchanged.
- DIVU 9/3 with `flush` 5 cycles into WAIT:
  - `stall` drops in the next cycle;
  - the later `div_ok` leaves HI/LO unchanged;
  - a DIVU 8/3 issued during DRAIN stalls until IDLE, then produces LO=2, HI=2.
- Assert `rst` while in WAIT, then inject `div_ok`: state is IDLE, `hi`=`lo`=0, and there is no write.
